// File: rtl/mult_pkg.sv
// Shared types for the shift-and-add multiplier: FSM state encoding and counter sizing.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  // Counter only has to hold WIDTH-1, so $clog2(WIDTH) bits suffice (WIDTH >= 2).
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/adder_nbits.sv
// Ripple-carry adder: s_o/c_o = a_i + b_i + c_i, purely combinational.
// Latency 0; no flow control.
module adder_nbits #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
  output logic [WIDTH-1:0] s_o,
  output logic             c_o
);

  logic [WIDTH:0] carry;

  assign carry[0] = c_i;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign s_o[i]       = a_i[i] ^ b_i[i] ^ carry[i];
    assign carry[i+1]   = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign c_o = carry[WIDTH];

endmodule

// File: rtl/mult_shift_add.sv
// Sequential unsigned WIDTH x WIDTH multiplier, one partial product per clock.
// Latency WIDTH+1 cycles from accepted start to done_o; start_i ignored while busy.
// MULT_ZERO_SKIP_EN: zero operand completes in 1 cycle without entering RUN.
module mult_shift_add #(
  parameter int WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] p_o
);

  import mult_pkg::*;

  localparam int CW = cnt_width(WIDTH);

  mult_state_t        state_q, state_d;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   acc_hi_q;
  logic [WIDTH-1:0]   acc_lo_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] p_q;

  logic [WIDTH-1:0]   sum;
  logic               carry;
  logic [2*WIDTH-1:0] acc_nxt;
  logic               start_zero;

  adder_nbits #(
    .WIDTH(WIDTH)
  ) u_adder (
    .a_i(acc_hi_q),
    .b_i(mcand_q),
    .c_i(1'b0),
    .s_o(sum),
    .c_o(carry)
  );

  // Carry-out becomes the new top bit after the shift, so the full sum is kept.
  always_comb begin
    acc_nxt = {1'b0, acc_hi_q, acc_lo_q[WIDTH-1:1]};
    if (acc_lo_q[0]) begin
      acc_nxt = {carry, sum, acc_lo_q[WIDTH-1:1]};
    end
  end

`ifdef MULT_ZERO_SKIP_EN
  assign start_zero = (a_i == '0) || (b_i == '0);
`else
  assign start_zero = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = start_zero ? DONE : RUN;
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
      p_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            mcand_q  <= a_i;
            acc_hi_q <= '0;
            acc_lo_q <= b_i;
            cnt_q    <= CW'(WIDTH - 1);
            if (start_zero) begin
              p_q <= '0;
            end
          end
        end
        RUN: begin
          {acc_hi_q, acc_lo_q} <= acc_nxt;
          if (cnt_q == '0) begin
            p_q <= acc_nxt;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o = (state_q == RUN);
  assign done_o = (state_q == DONE);
  assign p_o    = p_q;

endmodule

// File: tb/tb_mult_shift_add.sv
// Directed and randomized checks of mult_shift_add at WIDTH=8 and WIDTH=4.
module tb_mult_shift_add;

`ifdef MULT_ZERO_SKIP_EN
  localparam bit ZSKIP = 1'b1;
`else
  localparam bit ZSKIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8;
  logic [15:0] p8;
  logic        start4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        busy4, done4;
  logic [7:0]  p4;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mult_shift_add #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start8), .a_i(a8), .b_i(b8),
    .busy_o(busy8), .done_o(done8), .p_o(p8)
  );

  mult_shift_add #(.WIDTH(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start4), .a_i(a4), .b_i(b4),
    .busy_o(busy4), .done_o(done4), .p_o(p4)
  );

  // One operation on the 8-bit DUT; lat is the cycle index of done (0 = timeout).
  task automatic do_op8(input logic [7:0] a, input logic [7:0] b,
                        output int lat, output int nbusy, output logic [15:0] p);
    @(posedge clk); #1;
    start8 = 1'b1; a8 = a; b8 = b;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0; nbusy = 0; p = '0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (busy8) nbusy++;
      if (done8) begin
        lat = n; p = p8;
        break;
      end
    end
  endtask

  task automatic do_op4(input logic [3:0] a, input logic [3:0] b,
                        output int lat, output logic [7:0] p);
    @(posedge clk); #1;
    start4 = 1'b1; a4 = a; b4 = b;
    @(posedge clk); #1;
    start4 = 1'b0;
    lat = 0; p = '0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (done4) begin
        lat = n; p = p4;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || p8 !== 16'd0)
      $display("FAIL reset8: busy=%b done=%b p=%0d, want 0/0/0", busy8, done8, p8);
    else pass_cnt++;
    total_cnt++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || p4 !== 8'd0)
      $display("FAIL reset4: busy=%b done=%b p=%0d, want 0/0/0", busy4, done4, p4);
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (busy8 !== 1'b0 || done8 !== 1'b0)
      $display("FAIL idle_after_reset: busy=%b done=%b, want 0/0", busy8, done8);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    int lat, nbusy, ndone;
    logic [15:0] p;
    do_op8(8'd3, 8'd5, lat, nbusy, p);
    total_cnt++;
    if (lat !== 9) $display("FAIL basic_latency: got %0d, want 9", lat);
    else pass_cnt++;
    total_cnt++;
    if (nbusy !== 8) $display("FAIL basic_busy_cycles: got %0d, want 8", nbusy);
    else pass_cnt++;
    total_cnt++;
    if (p !== 16'd15) $display("FAIL basic_product: got %0d, want 15", p);
    else pass_cnt++;
    ndone = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    total_cnt++;
    if (p8 !== 16'd15 || ndone !== 0)
      $display("FAIL basic_hold: p=%0d extra_done=%0d, want 15/0", p8, ndone);
    else pass_cnt++;
  endtask

  task automatic test_corners();
    logic [7:0]  ta [3] = '{8'd255, 8'd255, 8'd1};
    logic [7:0]  tb [3] = '{8'd255, 8'd1, 8'd128};
    logic [15:0] te [3] = '{16'hFE01, 16'd255, 16'd128};
    int lat, nbusy;
    logic [15:0] p;
    for (int i = 0; i < 3; i++) begin
      do_op8(ta[i], tb[i], lat, nbusy, p);
      total_cnt++;
      if (p !== te[i] || lat !== 9)
        $display("FAIL corner%0d: %0d*%0d got p=%0d lat=%0d, want p=%0d lat=9",
                 i, ta[i], tb[i], p, lat, te[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_zero();
    int lat, nbusy;
    logic [15:0] p;
    do_op8(8'd0, 8'd77, lat, nbusy, p);
    total_cnt++;
    if (p !== 16'd0) $display("FAIL zero_product: got %0d, want 0", p);
    else pass_cnt++;
    total_cnt++;
    if (lat !== (ZSKIP ? 1 : 9))
      $display("FAIL zero_latency: got %0d, want %0d", lat, ZSKIP ? 1 : 9);
    else pass_cnt++;
    total_cnt++;
    if (nbusy !== (ZSKIP ? 0 : 8))
      $display("FAIL zero_busy_cycles: got %0d, want %0d", nbusy, ZSKIP ? 0 : 8);
    else pass_cnt++;
  endtask

  task automatic test_ignore_start();
    int ndone;
    logic [15:0] pfirst;
    @(posedge clk); #1;
    start8 = 1'b1; a8 = 8'd12; b8 = 8'd10;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'd7; b8 = 8'd7;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    ndone = 0; pfirst = '0;
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      if (done8) begin
        ndone++;
        if (ndone == 1) pfirst = p8;
      end
    end
    total_cnt++;
    if (ndone !== 1) $display("FAIL ignore_done_count: got %0d, want 1", ndone);
    else pass_cnt++;
    total_cnt++;
    if (pfirst !== 16'd120 || p8 !== 16'd120)
      $display("FAIL ignore_product: got %0d/%0d, want 120", pfirst, p8);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    int lat, nbusy, ndone;
    logic [15:0] p;
    @(posedge clk); #1;
    start8 = 1'b1; a8 = 8'd200; b8 = 8'd3;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (busy8 !== 1'b1) $display("FAIL abort_busy_before: got %b, want 1", busy8);
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || p8 !== 16'd0)
      $display("FAIL abort_state: busy=%b done=%b p=%0d, want 0/0/0", busy8, done8, p8);
    else pass_cnt++;
    ndone = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    total_cnt++;
    if (ndone !== 0) $display("FAIL abort_no_done: got %0d pulses, want 0", ndone);
    else pass_cnt++;
    do_op8(8'd6, 8'd7, lat, nbusy, p);
    total_cnt++;
    if (p !== 16'd42 || lat !== 9)
      $display("FAIL after_abort: p=%0d lat=%0d, want 42/9", p, lat);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int idx [4];
    int ndone;
    @(posedge clk); #1;
    start8 = 1'b1; a8 = 8'd9; b8 = 8'd11;
    ndone = 0;
    for (int n = 0; n < 46; n++) begin
      @(negedge clk);
      if (done8) begin
        if (ndone < 4) idx[ndone] = n;
        ndone++;
        total_cnt++;
        if (p8 !== 16'd99) $display("FAIL b2b_product: got %0d, want 99", p8);
        else pass_cnt++;
      end
    end
    start8 = 1'b0;
    total_cnt++;
    if (ndone !== 4) $display("FAIL b2b_pulse_count: got %0d, want 4", ndone);
    else pass_cnt++;
    if (ndone >= 4) begin
      for (int i = 1; i < 4; i++) begin
        total_cnt++;
        if (idx[i] - idx[i-1] !== 10)
          $display("FAIL b2b_interval%0d: got %0d, want 10", i, idx[i] - idx[i-1]);
        else pass_cnt++;
      end
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_random8();
    int lat, nbusy, want_lat;
    logic [7:0]  a, b;
    logic [15:0] p, want;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      if (i < 4) b = 8'd0;
      want = 16'(a) * 16'(b);
      want_lat = (ZSKIP && (a == 8'd0 || b == 8'd0)) ? 1 : 9;
      do_op8(a, b, lat, nbusy, p);
      total_cnt++;
      if (p !== want || lat !== want_lat)
        $display("FAIL rand8: %0d*%0d got p=%0d lat=%0d, want p=%0d lat=%0d",
                 a, b, p, lat, want, want_lat);
      else pass_cnt++;
    end
  endtask

  task automatic test_random4();
    int lat, want_lat;
    logic [3:0] a, b;
    logic [7:0] p, want;
    for (int i = 0; i < 1000; i++) begin
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      if (i == 0) begin a = 4'd15; b = 4'd15; end
      want = 8'(a) * 8'(b);
      want_lat = (ZSKIP && (a == 4'd0 || b == 4'd0)) ? 1 : 5;
      do_op4(a, b, lat, p);
      total_cnt++;
      if (p !== want || lat !== want_lat)
        $display("FAIL rand4: %0d*%0d got p=%0d lat=%0d, want p=%0d lat=%0d",
                 a, b, p, lat, want, want_lat);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_zero();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    test_random8();
    test_random4();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
